// File: rtl/width_128to24.sv
// width_128to24: repacks a stream of 128-bit words into 24-bit words.
// Three input words (384 bits) make exactly sixteen output words. Bits are
// kept MSB-first in a left-aligned 152-bit buffer. The fill count alone tells
// where the next word lands and where a 384-bit group ends, so no separate
// phase counter is needed.
module width_128to24 (
   input  logic         clk,
   input  logic         rst,
   input  logic         valid_in,
   input  logic [127:0] data_in,
   output logic         ready_in,
   output logic         valid_out,
   output logic [23:0]  data_out,
   input  logic         ready_out,
   output logic         last_out
);

   // Valid bits occupy buf_q[151 -: cnt_q]. Everything below them is zero.
   logic [151:0] buf_q, buf_d;
   logic [7:0]   cnt_q, cnt_d;

   // New input word, left-aligned, before it is shifted down past the leftover bits.
   logic [151:0] ins_w;
   logic         in_fire, out_fire;

   assign ins_w = {data_in, 24'd0};

   // The handshake flags depend only on the fill count. Accepting input only
   // when fewer than 24 bits remain means input and output never fire together.
   assign ready_in  = (cnt_q < 8'd24);
   assign valid_out = (cnt_q >= 8'd24);
   assign last_out  = (cnt_q == 8'd24);
   assign data_out  = buf_q[151:128];

   assign in_fire  = valid_in && ready_in;
   assign out_fire = valid_out && ready_out;

   // Next-state logic: append the input word below the leftover bits, or pop
   // 24 bits off the top.
   always_comb begin
      buf_d = buf_q;
      cnt_d = cnt_q;
      if (in_fire) begin
         // cnt is 0, 8 or 16 here. The bits below the valid region are zero,
         // so OR-ing the shifted word in places it after the leftover bits.
         buf_d = buf_q | (ins_w >> cnt_q);
         cnt_d = cnt_q + 8'd128;
      end else if (out_fire) begin
         buf_d = {buf_q[127:0], 24'd0};
         cnt_d = cnt_q - 8'd24;
      end
   end

   // State registers. Reset discards all buffered bits immediately.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         buf_q <= '0;
         cnt_q <= '0;
      end else begin
         buf_q <= buf_d;
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: tb/tb_width_128to24.sv
// Self-checking bench for width_128to24. A bit-queue reference model predicts
// every output. It is backed by a literal vector table for the continuous
// stream and by directed sequences for starvation, backpressure and reset.
module tb_width_128to24;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         valid_in = 1'b0;
   logic [127:0] data_in = '0;
   logic         ready_out = 1'b0;
   logic         ready_in, valid_out, last_out;
   logic [23:0]  data_out;

   width_128to24 dut (
      .clk(clk), .rst(rst), .valid_in(valid_in), .data_in(data_in),
      .ready_in(ready_in), .valid_out(valid_out), .data_out(data_out),
      .ready_out(ready_out), .last_out(last_out)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;
   bit q[$];          // model: pending bits, oldest first
   int out_cnt = 0;   // output words transferred since the last reset

   typedef struct {
      logic       vi;
      logic       ro;
      int         w;
      logic       eri;
      logic       evo;
      logic       elast;
      logic [23:0] edo;
   } tv_t;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic check_model();
      logic [23:0] e;
      bit evo;
      e = '0;
      for (int i = 0; i < 24 && i < q.size(); i++) e[23-i] = q[i];
      evo = (q.size() >= 24);
      chk("ready_in", 32'(ready_in), 32'(q.size() < 24));
      chk("valid_out", 32'(valid_out), 32'(evo));
      chk("last_out", 32'(last_out), 32'(evo && (out_cnt % 16 == 15)));
      chk("data_out", 32'(data_out), 32'(e));
   endtask

   // Check, clock once, advance the model, and return at the next negedge.
   task automatic tick();
      bit fi, fo;
      fi = valid_in && (q.size() < 24);
      fo = ready_out && (q.size() >= 24);
      check_model();
      @(posedge clk);
      if (fi) for (int i = 127; i >= 0; i--) q.push_back(data_in[i]);
      if (fo) begin
         repeat (24) void'(q.pop_front());
         out_cnt++;
      end
      @(negedge clk);
   endtask

   task automatic drive(input logic vi, input logic ro, input logic [127:0] d);
      valid_in = vi; ready_out = ro; data_in = d;
      #1;
   endtask

   task automatic apply(input logic vi, input logic ro, input logic [127:0] d);
      drive(vi, ro, d);
      tick();
   endtask

   // Assert reset in the low phase, check that it acts at once, release at a negedge.
   task automatic do_reset();
      valid_in = 1'b0;
      #2 rst = 1'b1;
      #1;
      q.delete();
      out_cnt = 0;
      check_model();
      chk("rst_data_out", 32'(data_out), 32'h0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   logic [383:0] stream;
   logic [127:0] W[3];
   tv_t tv[19];

   initial begin
      logic [127:0] w1, w2;
      int guard;

      // 16 incrementing 24-bit values packed MSB-first into three words.
      stream = '0;
      for (int k = 1; k <= 16; k++) stream = {stream[359:0], 24'(k)};
      for (int i = 0; i < 3; i++) W[i] = stream[383-128*i -: 128];

      tv = '{
         '{1'b1,1'b1,0, 1'b1,1'b0,1'b0,24'h000000},
         '{1'b1,1'b1,0, 1'b0,1'b1,1'b0,24'h000001},
         '{1'b1,1'b1,0, 1'b0,1'b1,1'b0,24'h000002},
         '{1'b1,1'b1,0, 1'b0,1'b1,1'b0,24'h000003},
         '{1'b1,1'b1,0, 1'b0,1'b1,1'b0,24'h000004},
         '{1'b1,1'b1,0, 1'b0,1'b1,1'b0,24'h000005},
         '{1'b1,1'b1,1, 1'b1,1'b0,1'b0,24'h000000},
         '{1'b1,1'b1,1, 1'b0,1'b1,1'b0,24'h000006},
         '{1'b1,1'b1,1, 1'b0,1'b1,1'b0,24'h000007},
         '{1'b1,1'b1,1, 1'b0,1'b1,1'b0,24'h000008},
         '{1'b1,1'b1,1, 1'b0,1'b1,1'b0,24'h000009},
         '{1'b1,1'b1,1, 1'b0,1'b1,1'b0,24'h00000A},
         '{1'b1,1'b1,2, 1'b1,1'b0,1'b0,24'h000000},
         '{1'b1,1'b1,2, 1'b0,1'b1,1'b0,24'h00000B},
         '{1'b1,1'b1,2, 1'b0,1'b1,1'b0,24'h00000C},
         '{1'b1,1'b1,2, 1'b0,1'b1,1'b0,24'h00000D},
         '{1'b1,1'b1,2, 1'b0,1'b1,1'b0,24'h00000E},
         '{1'b1,1'b1,2, 1'b0,1'b1,1'b0,24'h00000F},
         '{1'b1,1'b1,2, 1'b0,1'b1,1'b1,24'h000010}
      };

      @(negedge clk);
      do_reset();

      // Continuous stream: the first edge after reset release accepts word 1.
      for (int c = 0; c < 19; c++) begin
         drive(tv[c].vi, tv[c].ro, W[tv[c].w]);
         chk("tbl_ready_in", 32'(ready_in), 32'(tv[c].eri));
         chk("tbl_valid_out", 32'(valid_out), 32'(tv[c].evo));
         chk("tbl_last_out", 32'(last_out), 32'(tv[c].elast));
         chk("tbl_data_out", 32'(data_out), 32'(tv[c].edo));
         tick();
      end
      drive(1'b0, 1'b1, '0);
      chk("tbl_end_ready_in", 32'(ready_in), 32'h1);
      chk("tbl_end_valid_out", 32'(valid_out), 32'h0);

      // Input starvation after word 1, then word 2 arrives late.
      w1 = rnd128();
      w2 = rnd128();
      apply(1'b1, 1'b1, w1);
      repeat (5) apply(1'b0, 1'b1, '0);
      repeat (3) apply(1'b0, 1'b1, '0);
      chk("starve_ready_in", 32'(ready_in), 32'h1);
      chk("starve_valid_out", 32'(valid_out), 32'h0);
      chk("starve_leftover", 32'(data_out), 32'({w1[7:0], 16'h0}));
      apply(1'b1, 1'b1, w2);
      drive(1'b0, 1'b1, '0);
      chk("starve_word6", 32'(data_out), 32'({w1[7:0], w2[127:112]}));
      tick();
      guard = 0;
      while (out_cnt % 16 != 0 && guard < 200) begin
         apply(1'b1, 1'b1, rnd128());
         guard++;
      end
      chk("starve_group_done", 32'(guard < 200), 32'h1);

      // Backpressure: ready_out toggles. All-ones data is presented whenever
      // the block is not ready, and it must be ignored.
      for (int c = 0; c < 60; c++) begin
         bit nr;
         nr = (q.size() >= 24);
         apply(1'b1, 1'(c % 2), nr ? '1 : rnd128());
      end

      // Reset mid-group after 7 outputs, then a fresh group.
      do_reset();
      guard = 0;
      while (out_cnt < 7 && guard < 100) begin
         apply(1'b1, 1'b1, rnd128());
         guard++;
      end
      chk("pre_reset_outputs", 32'(out_cnt), 32'd7);
      do_reset();
      apply(1'b1, 1'b1, 128'hABCDEF0123456789ABCDEF0123456789);
      drive(1'b0, 1'b1, '0);
      chk("post_reset_first", 32'(data_out), 32'hABCDEF);
      tick();
      guard = 0;
      while (out_cnt < 16 && guard < 200) begin
         apply(1'b1, 1'b1, rnd128());
         guard++;
      end
      chk("post_reset_group", 32'(out_cnt), 32'd16);

      // Random valid_in/ready_out for 1000 groups.
      do_reset();
      guard = 0;
      while (out_cnt < 16000 && guard < 60000) begin
         apply(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0), rnd128());
         guard++;
      end
      chk("random_groups_done", 32'(out_cnt), 32'd16000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
